// File: rtl/bldc_commutator_dt.sv
// bldc_commutator_dt: six-step BLDC commutation with Hall filter, dead time and faults.
// Define BLDC_STALL_DET_EN to build the stall detector that drives fault[1].
module bldc_commutator_dt #(
  parameter int unsigned DT_CYCLES    = 8,
  parameter int unsigned DT_W         = 8,
  parameter int unsigned FILT_LEN     = 4,
  parameter int unsigned STALL_CYCLES = 1000000,
  parameter int unsigned STALL_W      = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       pwm_in,
  input  logic [2:0] hall,
  output logic [5:0] mosfet,
  output logic [2:0] hall_q,
  output logic       comm_tick,
  output logic [1:0] fault
);
  localparam logic [3:0]         FILT_MAX  = 4'(FILT_LEN - 1);
  localparam logic [DT_W-1:0]    DT_MAX    = DT_W'(DT_CYCLES);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);

  logic [2:0] s1_q, s2_q, prev_q;
  logic [3:0] fcnt_q, fcnt_d;
  logic       armed_q;
  logic       match, accept;

  assign match  = (s2_q == prev_q);
  assign accept = match && (fcnt_q == FILT_MAX) && (s2_q != hall_q);

  always_comb begin
    fcnt_d = 4'd0;
    if (match) begin
      fcnt_d = (fcnt_q == FILT_MAX) ? fcnt_q : fcnt_q + 4'd1;
    end
  end

  logic [2:0] hn, hi_req, lo_req;
  logic [5:0] req, mcomp, mos_d;

  // hn[k] is the Hall bit of phase k+1 (mod 3)
  assign hn = {hall_q[0], hall_q[2:1]};

  always_comb begin
    if (dir) begin
      hi_req = {3{pwm_in}} & hall_q & ~hn;
      lo_req = hn & ~hall_q;
    end else begin
      hi_req = {3{pwm_in}} & hn & ~hall_q;
      lo_req = hall_q & ~hn;
    end
  end

  always_comb begin
    req   = '0;
    mcomp = '0;
    for (int k = 0; k < 3; k++) begin
      req[2*k]     = hi_req[k];
      req[2*k+1]   = lo_req[k];
      mcomp[2*k]   = mosfet[2*k+1];
      mcomp[2*k+1] = mosfet[2*k];
    end
  end

  logic [5:0][DT_W-1:0] dt_q, dt_d;
  logic                 gate_ok;

  assign gate_ok = en && !(|fault);

  // the post-increment count gates turn-on, so it lands DT_CYCLES edges after turn-off
  always_comb begin
    dt_d  = '0;
    mos_d = '0;
    for (int s = 0; s < 6; s++) begin
      if (mcomp[s]) begin
        dt_d[s] = '0;
      end else if (dt_q[s] == DT_MAX) begin
        dt_d[s] = dt_q[s];
      end else begin
        dt_d[s] = dt_q[s] + DT_W'(1);
      end
      mos_d[s] = req[s] && (dt_d[s] == DT_MAX)
                 && !mcomp[s] && gate_ok;
    end
  end

  logic       hall_bad, flt_clr, stall_set;
  logic [1:0] fault_d;

  assign hall_bad = (hall_q == 3'b000) || (hall_q == 3'b111);
  assign flt_clr  = !en && !hall_bad;

  always_comb begin
    fault_d = fault | {stall_set, armed_q & hall_bad};
    if (flt_clr) begin
      fault_d = 2'b00;
    end
  end

`ifdef BLDC_STALL_DET_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = '0;
    if (en && !comm_tick) begin
      stall_d = (stall_q == STALL_MAX) ? stall_q
                                       : stall_q + STALL_W'(1);
    end
  end

  assign stall_set = en && (stall_d == STALL_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = ^STALL_MAX;
  assign stall_set    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 3'b000;
      s2_q      <= 3'b000;
      prev_q    <= 3'b000;
      fcnt_q    <= 4'd0;
      hall_q    <= 3'b000;
      armed_q   <= 1'b0;
      comm_tick <= 1'b0;
      fault     <= 2'b00;
      mosfet    <= 6'b0;
      dt_q      <= {6{DT_MAX}};
    end else begin
      s1_q      <= hall;
      s2_q      <= s1_q;
      prev_q    <= s2_q;
      fcnt_q    <= fcnt_d;
      comm_tick <= accept;
      if (accept) begin
        hall_q  <= s2_q;
        armed_q <= 1'b1;
      end
      fault     <= fault_d;
      mosfet    <= mos_d;
      dt_q      <= dt_d;
    end
  end

endmodule

// File: tb/tb_bldc_commutator_dt.sv
// tb_bldc_commutator_dt: scenario bench for bldc_commutator_dt.
// Expected gate patterns are queued at stimulus time and popped at output time.
module tb_bldc_commutator_dt;
  logic       clk = 1'b0;
  logic       rst, en, dir, pwm_in;
  logic [2:0] hall;
  logic [5:0] mosfet;
  logic [2:0] hall_q;
  logic       comm_tick;
  logic [1:0] fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0] m;
    logic [2:0] hq;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  bldc_commutator_dt #(
    .DT_CYCLES(8), .DT_W(8), .FILT_LEN(4),
    .STALL_CYCLES(100), .STALL_W(24)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir),
    .pwm_in(pwm_in), .hall(hall), .mosfet(mosfet),
    .hall_q(hall_q), .comm_tick(comm_tick), .fault(fault)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] fwd_pat(input logic [2:0] h);
    case (h)
      3'b001:  return 6'b100001;
      3'b011:  return 6'b100100;
      3'b010:  return 6'b000110;
      3'b110:  return 6'b010010;
      3'b100:  return 6'b011000;
      3'b101:  return 6'b001001;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; dir = 1'b1; pwm_in = 1'b1; hall = 3'b000;
    step(3);
    checks++;
    if (mosfet !== 6'b0) begin
      failures++; $display("FAIL rst_mos got=%b exp=%b", mosfet, 6'b0);
    end
    checks++;
    if (fault !== 2'b00) begin
      failures++; $display("FAIL rst_fault got=%b exp=00", fault);
    end
    checks++;
    if (comm_tick !== 1'b0) begin
      failures++; $display("FAIL rst_tick got=%b exp=0", comm_tick);
    end
    checks++;
    if (hall_q !== 3'b000) begin
      failures++; $display("FAIL rst_hallq got=%b exp=000", hall_q);
    end
    rst = 1'b0; en = 1'b1;
    step(10);
    checks++;
    if (fault !== 2'b00) begin
      failures++; $display("FAIL unarmed_fault got=%b exp=00", fault);
    end
    checks++;
    if (mosfet !== 6'b0) begin
      failures++; $display("FAIL unarmed_mos got=%b exp=%b", mosfet, 6'b0);
    end
  endtask

  task automatic test_forward();
    logic [2:0] seq [7];
    logic [5:0] prev;
    exp_t       e;
    int         ticks;
    seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
    prev = 6'b0;
    e = '{m: 6'b0, hq: 3'b0};
    for (int i = 0; i < 7; i++) begin
      hall = seq[i];
      sb.push_back('{m: fwd_pat(seq[i]), hq: seq[i]});
      ticks = 0;
      for (int c = 0; c < 20; c++) begin
        step(1);
        if (comm_tick) ticks++;
        if (c == 6) begin
          e = sb.pop_front();
          checks++;
          if (hall_q !== e.hq) begin
            failures++;
            $display("FAIL fwd_hallq step=%0d got=%b exp=%b", i, hall_q, e.hq);
          end
          checks++;
          if (mosfet !== prev) begin
            failures++;
            $display("FAIL fwd_hold step=%0d got=%b exp=%b", i, mosfet, prev);
          end
        end
        if (c == 7) begin
          checks++;
          if (mosfet !== e.m) begin
            failures++;
            $display("FAIL fwd_mos step=%0d got=%b exp=%b", i, mosfet, e.m);
          end
        end
      end
      checks++;
      if (ticks != 1) begin
        failures++; $display("FAIL fwd_ticks step=%0d got=%0d exp=1", i, ticks);
      end
      prev = e.m;
    end
  endtask

  task automatic test_dead_time();
    hall = 3'b010;
    for (int c = 0; c < 20; c++) begin
      step(1);
      checks++;
      if (mosfet[0] && mosfet[1]) begin
        failures++; $display("FAIL dt_overlap c=%0d got=%b exp=not_both", c, mosfet[1:0]);
      end
      if (c == 6) begin
        checks++;
        if (mosfet !== 6'b100001) begin
          failures++; $display("FAIL dt_hold got=%b exp=%b", mosfet, 6'b100001);
        end
      end
      if (c == 7) begin
        checks++;
        if (mosfet !== 6'b000100) begin
          failures++; $display("FAIL dt_off got=%b exp=%b", mosfet, 6'b000100);
        end
      end
      if (c > 7 && c < 15) begin
        checks++;
        if (mosfet[1] !== 1'b0) begin
          failures++; $display("FAIL dt_early c=%0d got=%b exp=0", c, mosfet[1]);
        end
      end
      if (c == 15) begin
        checks++;
        if (mosfet !== 6'b000110) begin
          failures++; $display("FAIL dt_on got=%b exp=%b", mosfet, 6'b000110);
        end
      end
    end
  endtask

  task automatic test_glitch();
    int ticks;
    ticks = 0;
    hall = 3'b110;
    for (int c = 0; c < 18; c++) begin
      if (c == 3) hall = 3'b010;
      step(1);
      if (comm_tick) ticks++;
    end
    checks++;
    if (ticks != 0) begin
      failures++; $display("FAIL glitch_ticks got=%0d exp=0", ticks);
    end
    checks++;
    if (hall_q !== 3'b010) begin
      failures++; $display("FAIL glitch_hallq got=%b exp=010", hall_q);
    end
    checks++;
    if (mosfet !== 6'b000110) begin
      failures++; $display("FAIL glitch_mos got=%b exp=%b", mosfet, 6'b000110);
    end
  endtask

  task automatic test_invalid();
    hall = 3'b111;
    step(10);
    checks++;
    if (fault !== 2'b01) begin
      failures++; $display("FAIL inv_fault got=%b exp=01", fault);
    end
    checks++;
    if (mosfet !== 6'b0) begin
      failures++; $display("FAIL inv_mos got=%b exp=%b", mosfet, 6'b0);
    end
    hall = 3'b001;
    step(10);
    checks++;
    if (hall_q !== 3'b001) begin
      failures++; $display("FAIL inv_hallq got=%b exp=001", hall_q);
    end
    checks++;
    if (fault !== 2'b01) begin
      failures++; $display("FAIL inv_sticky got=%b exp=01", fault);
    end
    checks++;
    if (mosfet !== 6'b0) begin
      failures++; $display("FAIL inv_gated got=%b exp=%b", mosfet, 6'b0);
    end
    en = 1'b0;
    step(1);
    checks++;
    if (fault !== 2'b00) begin
      failures++; $display("FAIL inv_clear got=%b exp=00", fault);
    end
    en = 1'b1;
    step(1);
    checks++;
    if (mosfet !== 6'b100001) begin
      failures++; $display("FAIL inv_resume got=%b exp=%b", mosfet, 6'b100001);
    end
  endtask

  task automatic test_reverse_pwm();
    exp_t e;
    logic p;
    for (int i = 0; i < 48; i++) begin
      p = (((i >> 2) & 1) == 0);
      pwm_in = p;
      dir = (i < 18);
      if (i < 18) e.m = {1'b1, 4'b0000, p};
      else if (i < 26) e.m = 6'b0;
      else e.m = {1'b0, p, 4'b0010};
      e.hq = 3'b001;
      sb.push_back(e);
      step(1);
      e = sb.pop_front();
      checks++;
      if (mosfet !== e.m) begin
        failures++; $display("FAIL rev_mos i=%0d got=%b exp=%b", i, mosfet, e.m);
      end
      checks++;
      if ((mosfet[0] && mosfet[1]) || (mosfet[2] && mosfet[3]) ||
          (mosfet[4] && mosfet[5])) begin
        failures++; $display("FAIL rev_overlap i=%0d got=%b exp=no_pair", i, mosfet);
      end
    end
  endtask

  task automatic test_stall();
    pwm_in = 1'b1;
    step(150);
`ifdef BLDC_STALL_DET_EN
    checks++;
    if (fault !== 2'b10) begin
      failures++; $display("FAIL stall_fault got=%b exp=10", fault);
    end
    checks++;
    if (mosfet !== 6'b0) begin
      failures++; $display("FAIL stall_mos got=%b exp=%b", mosfet, 6'b0);
    end
`else
    checks++;
    if (fault !== 2'b00) begin
      failures++; $display("FAIL nostall_fault got=%b exp=00", fault);
    end
    checks++;
    if (mosfet !== 6'b010010) begin
      failures++; $display("FAIL nostall_mos got=%b exp=%b", mosfet, 6'b010010);
    end
`endif
  endtask

  task automatic test_rst_dominance();
    rst = 1'b1;
    step(1);
    checks++;
    if (mosfet !== 6'b0) begin
      failures++; $display("FAIL rdom_mos got=%b exp=%b", mosfet, 6'b0);
    end
    checks++;
    if (hall_q !== 3'b000 || fault !== 2'b00) begin
      failures++; $display("FAIL rdom_state got=%b/%b exp=000/00", hall_q, fault);
    end
    rst = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_dead_time();
    test_glitch();
    test_invalid();
    test_reverse_pwm();
    test_stall();
    test_rst_dominance();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
